huffman_param: RTL and testbench

Parametrised Huffman coder for the image-statistics path. It histograms a burst of symbol samples over `NSYM` symbols and reports the per-symbol counts. It then builds a Huffman tree with a fixed, deterministic tie-break and emits a code word (`HC`) and a length mask (`M`) per symbol. Unlike the fixed 6-symbol, one-shot coder it replaces, it is frame-repeatable, has configurable symbol count and widths, and reports `busy`.

---
 rtl/huffman_param.sv | 174 +++++++++++++++++
 tb/tb_huffman_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_param.sv
// Frame-repeatable Huffman coder: histograms a burst of symbols, then builds
// a Huffman tree one merge per clock and reports per-symbol codes and masks.
//
// state  | meaning
// IDLE   | waiting for the first sample of a frame
// COUNT  | histogramming samples while gray_valid is high
// REPORT | counts published, tree leaves initialised, first merge
// MERGE  | remaining merges, one per edge
// DONE   | codes and masks published, returns to IDLE
module huffman_param #(
  parameter int NSYM = 6,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int HCW  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  gray_valid,
  input  logic [DW-1:0]         gray_data,
  output logic                  busy,
  output logic                  CNT_valid,
  output logic [NSYM*CW-1:0]    CNT,
  output logic                  code_valid,
  output logic [NSYM*HCW-1:0]   HC,
  output logic [NSYM*HCW-1:0]   M
);

  localparam int NN = 2*NSYM - 1;
  localparam int IW = $clog2(NN);
  localparam int WW = CW + $clog2(NSYM);
  localparam int LW = $clog2(HCW + 1);

  typedef enum logic [2:0] {IDLE, COUNT, REPORT, MERGE, DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0]   cnt      [NSYM];
  logic [WW-1:0]   weight   [NN];
  logic [NSYM-1:0] node_set [NN];
  logic            live     [NN];
  logic [HCW-1:0]  code     [NSYM];
  logic [LW-1:0]   len      [NSYM];
  logic [IW-1:0]   k;

  logic            in_rng;
  logic [DW-1:0]   sym_idx;
  logic            last_merge;
  logic            merge_en;
  logic [IW-1:0]   x, y, new_id;
  logic            have_x, have_y;

  assign in_rng     = (gray_data != '0) && (gray_data <= DW'(NSYM));
  assign sym_idx    = gray_data - DW'(1);
  assign last_merge = (k == IW'(NSYM - 1));
  assign merge_en   = ((state == REPORT) || (state == MERGE)) && !last_merge;
  assign new_id     = IW'(NSYM) + k;
  assign busy       = (state == REPORT) || (state == MERGE) || (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gray_valid)  state_nx = COUNT;
      COUNT:   if (!gray_valid) state_nx = REPORT;
      REPORT:  state_nx = MERGE;
      MERGE:   if (last_merge)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Ascending scan: an equal weight seen later has the higher ID and wins the tie.
  always_comb begin
    x      = '0;
    y      = '0;
    have_x = 1'b0;
    have_y = 1'b0;
    for (int i = 0; i < NN; i++) begin
      if (live[i]) begin
        if (!have_x || (weight[i] <= weight[x])) begin
          y      = x;
          have_y = have_x;
          x      = IW'(i);
          have_x = 1'b1;
        end else if (!have_y || (weight[i] <= weight[y])) begin
          y      = IW'(i);
          have_y = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      CNT_valid  <= 1'b0;
      code_valid <= 1'b0;
      CNT        <= '0;
      HC         <= '0;
      M          <= '0;
      k          <= '0;
      for (int s = 0; s < NSYM; s++) begin
        cnt[s]  <= '0;
        code[s] <= '0;
        len[s]  <= '0;
      end
      for (int j = 0; j < NN; j++) begin
        weight[j]   <= '0;
        node_set[j] <= '0;
        live[j]     <= 1'b0;
      end
    end else begin
      CNT_valid  <= 1'b0;
      code_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gray_valid) begin
            for (int s = 0; s < NSYM; s++)
              cnt[s] <= (in_rng && (sym_idx == DW'(s))) ? CW'(1) : '0;
          end
        end
        COUNT: begin
          if (gray_valid) begin
            for (int s = 0; s < NSYM; s++)
              if (in_rng && (sym_idx == DW'(s)) && (cnt[s] != '1))
                cnt[s] <= cnt[s] + CW'(1);
          end else begin
            CNT_valid <= 1'b1;
            k         <= '0;
            for (int s = 0; s < NSYM; s++) begin
              CNT[s*CW +: CW] <= cnt[s];
              weight[s]       <= WW'(cnt[s]);
              node_set[s]     <= NSYM'(1) << s;
              live[s]         <= 1'b1;
              code[s]         <= '0;
              len[s]          <= '0;
            end
            for (int j = NSYM; j < NN; j++) live[j] <= 1'b0;
          end
        end
        REPORT, MERGE: begin
          if (merge_en) begin
            live[x]          <= 1'b0;
            live[y]          <= 1'b0;
            live[new_id]     <= 1'b1;
            weight[new_id]   <= weight[x] + weight[y];
            node_set[new_id] <= node_set[x] | node_set[y];
            k                <= k + IW'(1);
            // x contributes a 1, y a 0; both subtrees grow one level deeper.
            for (int s = 0; s < NSYM; s++) begin
              if (node_set[x][s]) begin
                code[s] <= code[s] | (HCW'(1) << len[s]);
                len[s]  <= len[s] + LW'(1);
              end else if (node_set[y][s]) begin
                len[s]  <= len[s] + LW'(1);
              end
            end
          end else if (state == MERGE) begin
            code_valid <= 1'b1;
            for (int s = 0; s < NSYM; s++) begin
              HC[s*HCW +: HCW] <= code[s];
              M[s*HCW +: HCW]  <= (HCW'(1) << len[s]) - HCW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_param.sv
// Scoreboard bench for huffman_param at NSYM=6, 2 and 8 against a behavioural
// Huffman model with the same ordering rule.
module tb_huffman_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       gv [3];
  logic [7:0] gd [3];

  logic        b6, cv6, kv6, b2, cv2, kv2, b8, cv8, kv8;
  logic [47:0] cnt6, hc6, m6;
  logic [15:0] cnt2, hc2, m2;
  logic [63:0] cnt8, hc8, m8;

  huffman_param #(.NSYM(6), .DW(8), .CW(8), .HCW(8)) dut6 (
    .clk(clk), .reset(reset), .gray_valid(gv[0]), .gray_data(gd[0]), .busy(b6),
    .CNT_valid(cv6), .CNT(cnt6), .code_valid(kv6), .HC(hc6), .M(m6));
  huffman_param #(.NSYM(2), .DW(8), .CW(8), .HCW(8)) dut2 (
    .clk(clk), .reset(reset), .gray_valid(gv[1]), .gray_data(gd[1]), .busy(b2),
    .CNT_valid(cv2), .CNT(cnt2), .code_valid(kv2), .HC(hc2), .M(m2));
  huffman_param #(.NSYM(8), .DW(8), .CW(8), .HCW(8)) dut8 (
    .clk(clk), .reset(reset), .gray_valid(gv[2]), .gray_data(gd[2]), .busy(b8),
    .CNT_valid(cv8), .CNT(cnt8), .code_valid(kv8), .HC(hc8), .M(m8));

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int t_cnt = 0;
  int codes_seen = 0;
  logic [63:0] q_cnt[$], q_hc[$], q_m[$];
  logic [63:0] last_hc, last_m;
  int frame[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic mon(input logic cntv, input logic codev, input logic [63:0] c,
                     input logic [63:0] h, input logic [63:0] mm, input int n);
    if (cntv) begin
      check("cnt_expected", 64'(q_cnt.size() != 0), 64'd1);
      if (q_cnt.size() != 0) check("cnt", c, q_cnt.pop_front());
      t_cnt = cyc;
    end
    if (codev) begin
      check("code_expected", 64'(q_hc.size() != 0), 64'd1);
      if (q_hc.size() != 0) begin
        check("code_gap", 64'(cyc - t_cnt), 64'(n));
        check("hc", h, q_hc.pop_front());
        check("m", mm, q_m.pop_front());
        codes_seen++;
      end
    end
  endtask

  always @(negedge clk) mon(cv6, kv6, 64'(cnt6), 64'(hc6), 64'(m6), 6);
  always @(negedge clk) mon(cv2, kv2, 64'(cnt2), 64'(hc2), 64'(m2), 2);
  always @(negedge clk) mon(cv8, kv8, 64'(cnt8), 64'(hc8), 64'(m8), 8);

  task automatic model_run(input int n, input int c[8], output logic [63:0] hc,
                           output logic [63:0] mm);
    int w[16]; int st[16]; bit live[16]; int code[8]; int len[8]; int x, y;
    for (int i = 0; i < 16; i++) begin w[i] = 0; st[i] = 0; live[i] = 0; end
    for (int s = 0; s < 8; s++) begin code[s] = 0; len[s] = 0; end
    for (int s = 0; s < n; s++) begin w[s] = c[s]; st[s] = 1 << s; live[s] = 1; end
    for (int k = 0; k < n - 1; k++) begin
      x = -1;
      for (int i = 0; i < n + k; i++)
        if (live[i] && (x < 0 || w[i] < w[x] || (w[i] == w[x] && i > x))) x = i;
      y = -1;
      for (int i = 0; i < n + k; i++)
        if (i != x && live[i] && (y < 0 || w[i] < w[y] || (w[i] == w[y] && i > y))) y = i;
      for (int s = 0; s < n; s++) begin
        if (((st[x] >> s) & 1) != 0) begin code[s] |= 1 << len[s]; len[s]++; end
        else if (((st[y] >> s) & 1) != 0) len[s]++;
      end
      live[x] = 0; live[y] = 0;
      w[n+k] = w[x] + w[y]; st[n+k] = st[x] | st[y]; live[n+k] = 1;
    end
    hc = '0; mm = '0;
    for (int s = 0; s < n; s++) begin
      hc |= 64'(code[s]) << (8*s);
      mm |= 64'((1 << len[s]) - 1) << (8*s);
    end
  endtask

  task automatic send_frame(input int d, input int n);
    int c[8]; logic [63:0] ec, eh, em;
    for (int s = 0; s < 8; s++) c[s] = 0;
    for (int i = 0; i < frame.size(); i++) begin
      @(negedge clk);
      gv[d] = 1'b1;
      gd[d] = 8'(frame[i]);
      if (frame[i] >= 1 && frame[i] <= n && c[frame[i]-1] < 255) c[frame[i]-1]++;
    end
    @(negedge clk);
    gv[d] = 1'b0;
    ec = '0;
    for (int s = 0; s < n; s++) ec |= 64'(c[s]) << (8*s);
    model_run(n, c, eh, em);
    q_cnt.push_back(ec); q_hc.push_back(eh); q_m.push_back(em);
    last_hc = eh; last_m = em;
  endtask

  task automatic wait_code(input int target);
    for (int i = 0; i < 100 && codes_seen < target; i++) @(negedge clk);
    check("done_in_time", 64'(codes_seen >= target), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cnt6();
    int seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (cv6) seen = 1;
    end
    check("cnt_valid_seen", 64'(seen), 64'd1);
  endtask

  task automatic rand_frame(input int n);
    frame.delete();
    for (int i = 0; i < $urandom_range(1, 40); i++) frame.push_back($urandom_range(0, n + 1));
  endtask

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin gv[d] = 1'b0; gd[d] = '0; end
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(b6), 64'd0);
    check("rst_cnt", 64'(cnt6), 64'd0);
    check("rst_valids", 64'({cv6, kv6}), 64'd0);
    reset = 1'b1;

    // Reference frame
    frame.delete();
    foreach (frame[i]) ;
    for (int s = 1; s <= 6; s++) begin
      int reps;
      case (s) 1: reps = 10; 2: reps = 5; 3: reps = 3; 4: reps = 2; default: reps = 1; endcase
      for (int r = 0; r < reps; r++) frame.push_back(s);
    end
    send_frame(0, 6);
    wait_code(1);
    check("ref_cnt", 64'(cnt6), 64'h0101_0203_050A);
    check("ref_hc", 64'(hc6), 64'h03_02_00_01_01_01);
    check("ref_m", 64'(m6), 64'h1F_1F_0F_07_03_01);
    repeat (3) @(negedge clk);
    check("hold_hc", 64'(hc6), last_hc);
    check("hold_m", 64'(m6), last_m);

    // Tie-break with equal counts and two absent symbols
    frame.delete();
    for (int r = 0; r < 4; r++) for (int s = 1; s <= 4; s++) frame.push_back(s);
    send_frame(0, 6);
    wait_code(2);
    check("tie_hc", 64'(hc6), 64'h07_06_02_00_03_02);
    check("tie_m", 64'(m6), 64'h0F_0F_07_03_03_03);

    // Saturation with out-of-range values mixed in
    frame.delete();
    for (int i = 0; i < 300; i++) begin
      frame.push_back(1);
      if (i % 50 == 0) begin frame.push_back(0); frame.push_back(7); end
    end
    send_frame(0, 6);
    wait_code(3);
    check("sat_cnt1", 64'(cnt6[7:0]), 64'd255);

    // Sample offered during MERGE is dropped
    frame = '{1, 1, 2, 3, 3, 3, 4, 5, 6, 6};
    send_frame(0, 6);
    wait_cnt6();
    @(negedge clk);
    check("busy_merge", 64'(b6), 64'd1);
    gv[0] = 1'b1; gd[0] = 8'd2;
    @(negedge clk);
    gv[0] = 1'b0;
    wait_code(4);
    check("busy_idle", 64'(b6), 64'd0);
    frame = '{2, 2, 1, 4, 4, 4, 5};
    send_frame(0, 6);
    wait_code(5);

    // Reset during MERGE
    frame = '{3, 3, 3, 1, 2, 6, 6};
    send_frame(0, 6);
    wait_cnt6();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mrst_busy", 64'(b6), 64'd0);
    check("mrst_cnt", 64'(cnt6), 64'd0);
    check("mrst_hc", 64'(hc6), 64'd0);
    check("mrst_m", 64'(m6), 64'd0);
    check("mrst_valids", 64'({cv6, kv6}), 64'd0);
    q_hc.delete(); q_m.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("mrst_idle", 64'(b6), 64'd0);
    frame = '{5, 5, 5, 5, 6, 1, 2, 2, 3};
    send_frame(0, 6);
    wait_code(6);

    // NSYM=2
    frame = '{1, 1, 1, 2, 2, 2, 2, 2};
    send_frame(1, 2);
    wait_code(7);
    check("n2_hc", 64'(hc2), 64'h0001);
    check("n2_m", 64'(m2), 64'h0101);
    frame = '{2};
    send_frame(1, 2);
    wait_code(8);
    for (int f = 0; f < 4; f++) begin
      rand_frame(2);
      send_frame(1, 2);
      wait_code(9 + f);
    end

    // NSYM=8 random frames
    for (int f = 0; f < 6; f++) begin
      rand_frame(8);
      send_frame(2, 8);
      wait_code(13 + f);
    end

    check("queues_drained", 64'(q_cnt.size() + q_hc.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
